sync_down_counter: RTL and testbench

SYNC_DOWN_COUNTER -- requirements
Module: sync_down_counter

---
 rtl/sync_down_counter.sv | 108 ++++++++++
 tb/tb_sync_down_counter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/sync_down_counter.sv
// sync_down_counter
//   Loadable down counter with a small IDLE/RUN/DONE controller.
//   All state changes on the falling edge of clk; reset is synchronous,
//   active-high and sampled on that same edge.
//
//   Build option: define DOWN_CNT_RELOAD_EN to make the counter free-running.
//   After the terminal count it stays in RUN, and the next enabled cycle at
//   zero reloads the value last loaded. Without the macro the counter stops
//   in DONE at zero until the next load or reset.
module sync_down_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   output logic [WIDTH-1:0] q,
   output logic             zero,
   output logic             tc,
   output logic             busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [1:0]       state, state_nxt;
   logic [WIDTH-1:0] q_nxt;
   logic             tc_nxt;
`ifdef DOWN_CNT_RELOAD_EN
   logic [WIDTH-1:0] reload, reload_nxt;
`endif

   // Next-state logic: load beats counting, counting only happens in RUN.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no branch can
      // leave it unassigned and infer a latch.
      q_nxt     = q;
      state_nxt = state;
      tc_nxt    = 1'b0;
`ifdef DOWN_CNT_RELOAD_EN
      reload_nxt = reload;
`endif
      if (load) begin
         q_nxt     = load_val;
`ifdef DOWN_CNT_RELOAD_EN
         reload_nxt = load_val;
`endif
         // A zero load has nothing to count, so it never enters RUN and can
         // never produce a terminal-count pulse.
         state_nxt = (load_val != '0) ? RUN : IDLE;
      end else begin
         case (state)
            RUN: begin
               if (en) begin
                  if (q > ONE) begin
                     q_nxt = q - ONE;
                  end else if (q == ONE) begin
                     q_nxt  = '0;
                     tc_nxt = 1'b1;
`ifndef DOWN_CNT_RELOAD_EN
                     state_nxt = DONE;
`endif
                  end
`ifdef DOWN_CNT_RELOAD_EN
                  else begin
                     // Zero reached on the previous enabled cycle: start the
                     // next period silently.
                     q_nxt = reload;
                  end
`endif
               end
            end
            IDLE, DONE: ;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // State registers on the falling edge; reset wins over load and en.
   always_ff @(negedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the pre-edge values regardless of statement order.
      if (reset) begin
         state <= IDLE;
         q     <= '0;
         zero  <= 1'b1;
         tc    <= 1'b0;
`ifdef DOWN_CNT_RELOAD_EN
         reload <= '0;
`endif
      end else begin
         state <= state_nxt;
         q     <= q_nxt;
         zero  <= (q_nxt == '0);
         tc    <= tc_nxt;
`ifdef DOWN_CNT_RELOAD_EN
         reload <= reload_nxt;
`endif
      end
   end

   assign busy = (state == RUN);

endmodule

// File: tb/tb_sync_down_counter.sv
// tb_sync_down_counter
//   Self-checking bench for sync_down_counter (WIDTH=4). Honours
//   DOWN_CNT_RELOAD_EN the same way the design does.
module tb_sync_down_counter;

   localparam int WIDTH = 4;
`ifdef DOWN_CNT_RELOAD_EN
   localparam bit RELOAD_MODE = 1'b1;
`else
   localparam bit RELOAD_MODE = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             load = 1'b0;
   logic [WIDTH-1:0] load_val = '0;
   logic             en = 1'b0;
   logic [WIDTH-1:0] q;
   logic             zero, tc, busy;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: count value, value last loaded, and whether counting is live.
   int m_q      = 0;
   int m_reload = 0;
   bit m_active = 1'b0;
   bit m_tc     = 1'b0;

   sync_down_counter #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .load_val (load_val),
      .en       (en),
      .q        (q),
      .zero     (zero),
      .tc       (tc),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic       r;
      logic       l;
      logic [3:0] lv;
      logic       e;
      logic [3:0] q;
      logic       z;
      logic       t;
      logic       b;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input int actual, input int expected);
      n_cmp++;
      if (actual !== expected) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Model update from the behavioural rules, one active edge at a time.
   task automatic model_step(input bit r, input bit l, input int lv, input bit e);
      m_tc = 1'b0;
      if (r) begin
         m_q = 0; m_reload = 0; m_active = 1'b0;
      end else if (l) begin
         m_q = lv; m_reload = lv; m_active = (lv != 0);
      end else if (m_active && e) begin
         if (m_q == 0) begin
            m_q = m_reload;               // only reachable in reload mode
         end else begin
            m_q = m_q - 1;
            if (m_q == 0) begin
               m_tc = 1'b1;
               if (!RELOAD_MODE) m_active = 1'b0;
            end
         end
      end
   endtask

   // Inputs change at the rising edge, the DUT updates on the falling edge,
   // outputs are sampled on the following rising edge.
   task automatic drive(input bit r, input bit l, input int lv, input bit e);
      reset = r; load = l; load_val = WIDTH'(lv); en = e;
      @(negedge clk);
      @(posedge clk);
      model_step(r, l, lv, e);
   endtask

   task automatic check_all(input string tag, input int eq, input bit ez, input bit et, input bit eb);
      check({tag, "_q"},    int'(q),    eq);
      check({tag, "_zero"}, int'(zero), int'(ez));
      check({tag, "_tc"},   int'(tc),   int'(et));
      check({tag, "_busy"}, int'(busy), int'(eb));
   endtask

   initial begin
      // ---- Table-driven vectors (independent of the build option) ----
      vecs.push_back('{"rst",       1, 0, 0, 0, 0, 1, 0, 0});
      for (int i = 0; i < 5; i++)
         vecs.push_back('{"rst_en",  0, 0, 0, 1, 0, 1, 0, 0});
      vecs.push_back('{"ld9_en",    0, 1, 9, 1, 9, 0, 0, 1});
      vecs.push_back('{"en1",       0, 0, 0, 1, 8, 0, 0, 1});
      vecs.push_back('{"en0",       0, 0, 0, 0, 8, 0, 0, 1});
      vecs.push_back('{"en1b",      0, 0, 0, 1, 7, 0, 0, 1});
      vecs.push_back('{"ld0",       0, 1, 0, 0, 0, 1, 0, 0});
      vecs.push_back('{"ld0_en",    0, 0, 0, 1, 0, 1, 0, 0});
      vecs.push_back('{"ld5",       0, 1, 5, 0, 5, 0, 0, 1});
      vecs.push_back('{"rst_ld",    1, 1, 7, 1, 0, 1, 0, 0});
      vecs.push_back('{"after_rst", 0, 0, 0, 1, 0, 1, 0, 0});

      foreach (vecs[i]) begin
         drive(vecs[i].r, vecs[i].l, int'(vecs[i].lv), vecs[i].e);
         check_all($sformatf("v%0d_%s", i, vecs[i].name),
                   int'(vecs[i].q), vecs[i].z, vecs[i].t, vecs[i].b);
      end

      // ---- Load 3 then count: terminal count and, if built, auto reload ----
      drive(1, 0, 0, 0);
      drive(0, 1, 3, 1);
      check_all("ld3", 3, 0, 0, 1);
      for (int i = 1; i <= 12; i++) begin
         int eq;
         bit et, eb;
         if (RELOAD_MODE) begin
            eq = 3 - (i % 4);
            et = ((i % 4) == 3);
            eb = 1'b1;
         end else begin
            eq = (i < 3) ? 3 - i : 0;
            et = (i == 3);
            eb = (i < 3);
         end
         drive(0, 0, 0, 1);
         check_all($sformatf("cnt3_%0d", i), eq, (eq == 0), et, eb);
      end

      // ---- Reset mid-count aborts without a pulse ----
      drive(0, 1, 15, 0);
      for (int i = 0; i < 9; i++) begin
         drive(0, 0, 0, 1);
         check($sformatf("ld15_tc_%0d", i), int'(tc), 0);
      end
      check_all("ld15_at6", 6, 0, 0, 1);
      drive(1, 0, 0, 1);
      check_all("ld15_rst", 0, 1, 0, 0);
      drive(0, 0, 0, 1);
      check_all("ld15_post", 0, 1, 0, 0);

      // ---- Randomised traffic against the model ----
      for (int i = 0; i < 600; i++) begin
         bit r, l, e;
         int lv;
         r  = ($urandom_range(0, 31) == 0);
         l  = ($urandom_range(0, 7) == 0);
         e  = ($urandom_range(0, 3) != 0);
         lv = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 4) : $urandom_range(0, 15);
         drive(r, l, lv, e);
         check_all($sformatf("rnd%0d", i), m_q, (m_q == 0), m_tc, m_active);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
